// File: rtl/serdesphy_cdr_pkg.sv
// rtl/serdesphy_cdr_pkg.sv - shared NCO state encoding, default FCW constants and clamp helper
package serdesphy_cdr_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } nco_state_e;

    localparam logic [23:0] DEF_CENTER_FCW = 24'h400000;
    localparam logic [23:0] DEF_STEP_FCW   = 24'h000100;
    localparam logic [23:0] DEF_FCW_MIN    = 24'h200000;
    localparam logic [23:0] DEF_FCW_MAX    = 24'h600000;
    localparam logic [23:0] DEF_SLEW_STEP  = 24'h000400;
    localparam logic [23:0] DEF_RELOCK_THR = 24'h002000;

    // Wide signed clamp so both RX and TX NCOs can reuse it regardless of ACC_W.
    function automatic logic signed [63:0] clamp_s64(
        input logic signed [63:0] v,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

endpackage

// File: rtl/serdesphy_nco_slew.sv
// rtl/serdesphy_nco_slew.sv - control-word target register, clamp and slew-limited FCW
module serdesphy_nco_slew
    import serdesphy_cdr_pkg::*;
#(
    parameter int              ACC_W      = 24,
    parameter int              CTRL_W     = 8,
    parameter logic [ACC_W-1:0] CENTER_FCW = DEF_CENTER_FCW,
    parameter logic [ACC_W-1:0] STEP_FCW   = DEF_STEP_FCW,
    parameter logic [ACC_W-1:0] FCW_MIN    = DEF_FCW_MIN,
    parameter logic [ACC_W-1:0] FCW_MAX    = DEF_FCW_MAX,
    parameter logic [ACC_W-1:0] SLEW_STEP  = DEF_SLEW_STEP,
    parameter logic [ACC_W-1:0] RELOCK_THR = DEF_RELOCK_THR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [ACC_W-1:0]  fcw_o,
    output logic              far_o
);

    localparam int WIDE = ACC_W + CTRL_W + 1;
    localparam int MID  = 2 ** (CTRL_W - 1);

    logic [ACC_W-1:0]       target_q, target_d;
    logic [ACC_W-1:0]       fcw_q, fcw_d;
    logic signed [WIDE-1:0] code_off;
    logic signed [WIDE-1:0] target_wide;
    logic [ACC_W-1:0]       target_clamped;
    logic [ACC_W-1:0]       diff_up, diff_dn, diff_abs;

    always_comb begin
        code_off       = $signed(WIDE'(ctrl_i)) - $signed(WIDE'(MID));
        target_wide    = $signed(WIDE'(CENTER_FCW)) + code_off * $signed(WIDE'(STEP_FCW));
        target_clamped = ACC_W'(clamp_s64(64'(target_wide),
                                          $signed(64'(FCW_MIN)),
                                          $signed(64'(FCW_MAX))));

        target_d = target_q;
        if (clear_i) begin
            target_d = CENTER_FCW;
        end else if (load_i) begin
            target_d = target_clamped;
        end

        diff_up  = target_q - fcw_q;
        diff_dn  = fcw_q - target_q;
        diff_abs = (target_q >= fcw_q) ? diff_up : diff_dn;

        // Step by at most SLEW_STEP, landing exactly on target when within reach.
        fcw_d = fcw_q;
        if (clear_i) begin
            fcw_d = CENTER_FCW;
        end else if (target_q > fcw_q) begin
            fcw_d = (diff_up > SLEW_STEP) ? fcw_q + SLEW_STEP : target_q;
        end else if (target_q < fcw_q) begin
            fcw_d = (diff_dn > SLEW_STEP) ? fcw_q - SLEW_STEP : target_q;
        end

        far_o = (diff_abs > RELOCK_THR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= CENTER_FCW;
            fcw_q    <= CENTER_FCW;
        end else begin
            target_q <= target_d;
            fcw_q    <= fcw_d;
        end
    end

    assign fcw_o = fcw_q;

endmodule

// File: rtl/serdesphy_cdr_nco.sv
// rtl/serdesphy_cdr_nco.sv - CDR NCO: phase accumulator, multi-phase taps, tick detect, lock FSM
module serdesphy_cdr_nco
    import serdesphy_cdr_pkg::*;
#(
    parameter int               ACC_W       = 24,
    parameter int               CTRL_W      = 8,
    parameter logic [ACC_W-1:0] CENTER_FCW  = DEF_CENTER_FCW,
    parameter logic [ACC_W-1:0] STEP_FCW    = DEF_STEP_FCW,
    parameter logic [ACC_W-1:0] FCW_MIN     = DEF_FCW_MIN,
    parameter logic [ACC_W-1:0] FCW_MAX     = DEF_FCW_MAX,
    parameter logic [ACC_W-1:0] SLEW_STEP   = DEF_SLEW_STEP,
    parameter int               LOCK_CYCLES = 50,
    parameter logic [ACC_W-1:0] RELOCK_THR  = DEF_RELOCK_THR,
    parameter int               NUM_PHASES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  ctrl_valid,
    input  logic [CTRL_W-1:0]     cdr_control,
    output logic                  vco_out,
    output logic [NUM_PHASES-1:0] vco_phases,
    output logic                  vco_tick,
    output logic                  vco_ready,
    output logic [ACC_W-1:0]      fcw_out
);

    localparam int               CNT_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_CYCLES);
    localparam logic [ACC_W-1:0] PH_STEP = ACC_W'(1) << (ACC_W - $clog2(NUM_PHASES));

    nco_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ACC_W-1:0]      tap;
    logic [NUM_PHASES-1:0] phases_q, phases_d;
    logic                  tick_q, tick_d;
    logic                  ready_q, ready_d;
    logic [ACC_W-1:0]      fcw;
    logic                  far;

    serdesphy_nco_slew #(
        .ACC_W      (ACC_W),
        .CTRL_W     (CTRL_W),
        .CENTER_FCW (CENTER_FCW),
        .STEP_FCW   (STEP_FCW),
        .FCW_MIN    (FCW_MIN),
        .FCW_MAX    (FCW_MAX),
        .SLEW_STEP  (SLEW_STEP),
        .RELOCK_THR (RELOCK_THR)
    ) u_slew (
        .clk     (clk),
        .rst     (rst),
        .clear_i (~enable),
        .load_i  (ctrl_valid),
        .ctrl_i  (cdr_control),
        .fcw_o   (fcw),
        .far_o   (far)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = (tick_q && (cnt_q != LOCK_N)) ? cnt_q + CNT_W'(1) : cnt_q;

        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (enable) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // The current tick is folded into the count before the lock compare.
                cnt_d = cnt_inc;
                if ((cnt_inc == LOCK_N) && !far) state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = '0;
                if (far) state_d = ST_SETTLE;
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        if (!enable) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (!enable) begin
            acc_d = '0;
        end else if (state_q != ST_OFF) begin
            acc_d = acc_q + fcw;
        end

        phases_d = '0;
        tap      = '0;
        if (state_d != ST_OFF) begin
            for (int k = 0; k < NUM_PHASES; k++) begin
                tap         = acc_d - ACC_W'(k) * PH_STEP;
                phases_d[k] = tap[ACC_W-1];
            end
        end

        tick_d  = phases_d[0] & ~phases_q[0];
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            acc_q    <= '0;
            phases_q <= '0;
            tick_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            phases_q <= phases_d;
            tick_q   <= tick_d;
            ready_q  <= ready_d;
        end
    end

    assign vco_out    = phases_q[0];
    assign vco_phases = phases_q;
    assign vco_tick   = tick_q;
    assign vco_ready  = ready_q;
    assign fcw_out    = fcw;

endmodule

// File: tb/tb_serdesphy_cdr_nco.sv
// tb/tb_serdesphy_cdr_nco.sv - directed self-checking bench for serdesphy_cdr_nco
module tb_serdesphy_cdr_nco;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, ctrl_valid;
    logic [7:0]  cdr_control;
    logic        vco_out, vco_tick, vco_ready;
    logic [3:0]  vco_phases;
    logic [23:0] fcw_out;

    logic        en_c, cv_c;
    logic [7:0]  ctl_c;
    logic        out_c, tick_c, ready_c;
    logic [3:0]  ph_c;
    logic [23:0] fcw_c;

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_ph [4];
    logic       exp_out [4];
    logic       exp_tick [4];

    always #5 clk = ~clk;

    serdesphy_cdr_nco u_dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ctrl_valid  (ctrl_valid),
        .cdr_control (cdr_control),
        .vco_out     (vco_out),
        .vco_phases  (vco_phases),
        .vco_tick    (vco_tick),
        .vco_ready   (vco_ready),
        .fcw_out     (fcw_out)
    );

    serdesphy_cdr_nco #(.STEP_FCW(24'h010000)) u_clamp (
        .clk         (clk),
        .rst         (rst),
        .enable      (en_c),
        .ctrl_valid  (cv_c),
        .cdr_control (ctl_c),
        .vco_out     (out_c),
        .vco_phases  (ph_c),
        .vco_tick    (tick_c),
        .vco_ready   (ready_c),
        .fcw_out     (fcw_c)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out"},    vco_out,    0);
        check({tag, "_phases"}, vco_phases, 0);
        check({tag, "_tick"},   vco_tick,   0);
        check({tag, "_ready"},  vco_ready,  0);
        check({tag, "_fcw"},    fcw_out,    32'h400000);
    endtask

    // Counts ticks from the current sample; ready must rise exactly one clk after the 50th.
    task automatic settle_check(input string tag, input int n0);
        int n;
        bit early;
        n     = n0;
        early = 1'b0;
        for (int g = 0; g < 2000; g++) begin
            if (vco_tick) n++;
            if (n == 50) break;
            if (vco_ready) early = 1'b1;
            cyc();
        end
        check({tag, "_ticks"},         n,         50);
        check({tag, "_early_ready"},   early,     0);
        check({tag, "_ready_at_tick"}, vco_ready, 0);
        cyc();
        check({tag, "_ready"},         vco_ready, 1);
    endtask

    initial begin
        int n;
        int p;
        bit found;

        exp_out[0]  = 1'b1; exp_out[1]  = 1'b1; exp_out[2]  = 1'b0; exp_out[3]  = 1'b0;
        exp_tick[0] = 1'b1; exp_tick[1] = 1'b0; exp_tick[2] = 1'b0; exp_tick[3] = 1'b0;
        exp_ph[0]   = 4'b1001; exp_ph[1] = 4'b0011; exp_ph[2] = 4'b0110; exp_ph[3] = 4'b1100;

        rst         = 1'b1;
        enable      = 1'b0;
        ctrl_valid  = 1'b0;
        cdr_control = 8'd128;
        en_c        = 1'b0;
        cv_c        = 1'b0;
        ctl_c       = 8'd128;
        repeat (2) cyc();
        check_reset_vals("reset");
        rst = 1'b0;
        cyc();

        // Centre frequency and initial lock
        enable      = 1'b1;
        ctrl_valid  = 1'b1;
        cdr_control = 8'd128;
        cyc();
        settle_check("centre", 0);
        check("centre_fcw", fcw_out, 32'h400000);

        found = 1'b0;
        for (int g = 0; g < 10; g++) begin
            if (vco_tick) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check("centre_tick_found", found, 1);
        for (int t = 0; t < 8; t++) begin
            check($sformatf("centre_out_t%0d", t),    vco_out,    exp_out[t % 4]);
            check($sformatf("centre_phases_t%0d", t), vco_phases, exp_ph[t % 4]);
            check($sformatf("centre_tick_t%0d", t),   vco_tick,   exp_tick[t % 4]);
            cyc();
        end

        // Small step: slew-limited ramp, ready held
        cdr_control = 8'd136;
        cyc();
        check("slew_e0_fcw", fcw_out, 32'h400000);
        check("slew_e0_ready", vco_ready, 1);
        cyc();
        check("slew_e1_fcw", fcw_out, 32'h400400);
        cyc();
        check("slew_e2_fcw", fcw_out, 32'h400800);
        check("slew_e2_ready", vco_ready, 1);
        cyc();
        check("slew_e3_fcw", fcw_out, 32'h400800);
        check("slew_e3_ready", vco_ready, 1);

        // Large step: ready drops, ramp to 0x407F00, re-qualify
        cdr_control = 8'd255;
        cyc();
        check("relock_e0_ready", vco_ready, 1);
        check("relock_e0_fcw", fcw_out, 32'h400800);
        cyc();
        check("relock_e1_ready", vco_ready, 0);
        check("relock_e1_fcw", fcw_out, 32'h400C00);
        n = 0;
        for (int j = 1; j < 30; j++) begin
            if (vco_tick) n++;
            if (j == 29) check("relock_e29_fcw", fcw_out, 32'h407C00);
            cyc();
        end
        check("relock_e30_fcw", fcw_out, 32'h407F00);
        settle_check("relock", n);
        check("relock_final_fcw", fcw_out, 32'h407F00);

        // Enable drop with a simultaneous control word
        enable      = 1'b0;
        ctrl_valid  = 1'b1;
        cdr_control = 8'd200;
        cyc();
        check_reset_vals("endrop");
        ctrl_valid = 1'b0;
        enable     = 1'b1;
        cyc();
        check("reenable_fcw", fcw_out, 32'h400000);
        settle_check("reenable", 0);
        check("reenable_final_fcw", fcw_out, 32'h400000);

        // Asynchronous reset mid-RUN
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        cyc();
        rst = 1'b0;
        cyc();
        settle_check("post_reset", 0);

        // Clamp instance
        en_c  = 1'b1;
        cv_c  = 1'b1;
        ctl_c = 8'd0;
        repeat (2100) cyc();
        check("clamp_min_fcw", fcw_c, 32'h200000);
        found = 1'b0;
        for (int g = 0; g < 20; g++) begin
            if (tick_c) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check("clamp_min_tick_found", found, 1);
        p = 0;
        for (int g = 0; g < 20; g++) begin
            cyc();
            p++;
            if (tick_c) break;
        end
        check("clamp_min_period", p, 8);

        ctl_c = 8'd255;
        cyc();
        check("clamp_max_e0_fcw", fcw_c, 32'h200000);
        cyc();
        check("clamp_max_e1_fcw", fcw_c, 32'h200400);
        repeat (4200) cyc();
        check("clamp_max_fcw", fcw_c, 32'h600000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
